// File: rtl/sprite_shadow_writer_if.sv
// Sprite register bus: CPU shadow-write port in, display-controller register write port out.
// master is the shadow writer itself; slave is the surrounding CPU decode / display side.
interface sprite_shadow_writer_if;
  logic        cpu_write;
  logic [6:0]  cpu_index;
  logic [15:0] cpu_value;
  logic        register_write;
  logic [6:0]  register_index;
  logic [15:0] register_write_value;

  modport master (
    input  cpu_write,
    input  cpu_index,
    input  cpu_value,
    output register_write,
    output register_index,
    output register_write_value
  );

  modport slave (
    output cpu_write,
    output cpu_index,
    output cpu_value,
    input  register_write,
    input  register_index,
    input  register_write_value
  );
endinterface

// File: rtl/sprite_shadow_writer.sv
// Shadow bank for sprite registers; on each vblank rise, replays dirty entries to the display
// controller, one register write per cycle, so sprite updates never tear mid-frame.
module sprite_shadow_writer #(
  parameter int unsigned FIRST_INDEX = 2,
  parameter int unsigned NUM_REGS    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  sprite_shadow_writer_if.master        bus,
  input  logic                          in_vblank_i,
  output logic                          busy_o,
  output logic                          frame_done_o
);

  localparam int unsigned PtrW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                       state_q, state_d;
  logic [PtrW-1:0]              ptr_q, ptr_d;
  logic [NUM_REGS-1:0][15:0]    shadow_q, shadow_d;
  logic [NUM_REGS-1:0]          dirty_q, dirty_d;
  logic                         vblank_q, vblank_d;
  logic                         wr_q, wr_d;
  logic [6:0]                   idx_q, idx_d;
  logic [15:0]                  val_q, val_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         vblank_rise;
  logic                         last_entry;

  assign vblank_d    = in_vblank_i;
  assign vblank_rise = in_vblank_i & ~vblank_q;
  assign last_entry  = (ptr_q == PtrW'(NUM_REGS - 1));

  // vblank_q resets high so a vblank already asserted at reset release is not a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      shadow_q <= '0;
      dirty_q  <= '0;
      vblank_q <= 1'b1;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      val_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      vblank_q <= vblank_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (vblank_rise) begin
          state_d = StScan;
          ptr_d   = '0;
        end
      end
      StScan: begin
        if (last_entry) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    wr_d     = 1'b0;
    idx_d    = '0;
    val_d    = '0;
    busy_d   = (state_d == StScan);
    done_d   = (state_q == StScan) && last_entry;
    if (state_q == StScan && dirty_q[ptr_q]) begin
      wr_d           = 1'b1;
      idx_d          = 7'(FIRST_INDEX + 32'(ptr_q));
      val_d          = shadow_q[ptr_q];
      dirty_d[ptr_q] = 1'b0;
    end
    // Applied after the scan clear: a same-cycle CPU write keeps the entry dirty.
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (bus.cpu_write && bus.cpu_index == 7'(FIRST_INDEX + k)) begin
        shadow_d[k] = bus.cpu_value;
        dirty_d[k]  = 1'b1;
      end
    end
  end

  assign bus.register_write       = wr_q;
  assign bus.register_index       = idx_q;
  assign bus.register_write_value = val_q;
  assign busy_o                   = busy_q;
  assign frame_done_o             = done_q;

endmodule
